// File: rtl/disp_scan_ctrl.sv
// Scan sequencer for a 16x16 LED matrix: double-buffered frame, per-pixel blank + dwell.
// Define DISP_SCAN_SKIP_DARK_EN to spend a single cycle on dark pixels (no blank, no dwell).
module disp_scan_ctrl #(
  parameter int unsigned DWELL = 64,
  parameter int unsigned BLANK = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run_i,
  input  logic        wr_en_i,
  input  logic [3:0]  wr_row_i,
  input  logic [0:15] wr_data_i,
  input  logic        swap_req_i,
  output logic        swap_ack_o,
  output logic [7:0]  addr_o,
  output logic        enable_o,
  output logic        frame_done_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StBlank, StOn} state_e;

  localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       addr_q;
  logic             sel_q;
  logic             enable_q;
  logic             swap_ack_q;
  logic             frame_done_q;
  logic             busy_q;
  logic [0:15]      buf_q [2][16];

  logic [0:15] front_row;
  logic        pix_lit;
  logic        pix_end;

  // pix_end marks the final cycle spent on the current address.
  always_comb begin
    front_row = buf_q[sel_q][addr_q[7:4]];
    pix_lit   = front_row[addr_q[3:0]];
    pix_end   = 1'b0;
    case (state_q)
`ifdef DISP_SCAN_SKIP_DARK_EN
      StBlank: pix_end = !pix_lit;
`else
      StBlank: pix_end = 1'b0;
`endif
      StOn:    pix_end = (cnt_q == DwellLast);
      default: pix_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      addr_q       <= '0;
      sel_q        <= 1'b0;
      enable_q     <= 1'b0;
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < 16; r++) begin
          buf_q[b][r] <= '0;
        end
      end
    end else begin
      swap_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;

      // Uses the pre-swap select, so a write at the swap edge lands in the new front.
      if (wr_en_i) begin
        buf_q[~sel_q][wr_row_i] <= wr_data_i;
      end

      case (state_q)
        StIdle: begin
          addr_q   <= '0;
          enable_q <= 1'b0;
          cnt_q    <= '0;
          if (run_i) begin
            state_q <= StBlank;
            busy_q  <= 1'b1;
          end
        end
        StBlank: begin
          enable_q <= 1'b0;
          if (cnt_q == BlankLast) begin
            state_q  <= StOn;
            cnt_q    <= '0;
            enable_q <= pix_lit;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StOn: begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase

      if (pix_end) begin
        cnt_q    <= '0;
        enable_q <= 1'b0;
        if (addr_q != 8'hFF) begin
          addr_q  <= addr_q + 8'd1;
          state_q <= StBlank;
        end else begin
          addr_q       <= '0;
          frame_done_q <= 1'b1;
          if (swap_req_i) begin
            sel_q      <= ~sel_q;
            swap_ack_q <= 1'b1;
          end
          state_q <= run_i ? StBlank : StIdle;
          busy_q  <= run_i;
        end
      end
    end
  end

  assign swap_ack_o   = swap_ack_q;
  assign addr_o       = addr_q;
  assign enable_o     = enable_q;
  assign frame_done_o = frame_done_q;
  assign busy_o       = busy_q;

endmodule
